adex_isi_encoder: RTL and testbench
===================================

// Module: adex_isi_encoder
// PURPOSE
//   Downstream consumer of the AdEx neuron core's spike pulse. Measures the
//   inter-spike interval (ISI) in neuron update steps and buffers ISI samples
//   in a small FIFO. Samples drain through a valid/ready byte interface to the
//   tile outputs. Also keeps a free-running spike tally for rate readout.
// PARAMETERS
//   ISI_W       8  width of ISI counter and output sample (bits)
//   FIFO_DEPTH  4  ISI FIFO entries; power of two, >=2
//   CNT_W       3  width of fifo_count, = log2(FIFO_DEPTH)+1
// PORTS
//   clk          in   1      clock
//   rst          in   1      synchronous reset, active-high
//   step_en      in   1      one-cycle strobe per neuron integration step
//   spike        in   1      one-cycle spike pulse from neuron core
//   clear        in   1      synchronous soft clear, same effect as rst
//   isi_data     out  ISI_W  ISI sample at FIFO head
//   isi_valid    out  1      isi_data valid (FIFO not empty)
//   isi_ready    in   1      consumer accepts isi_data this cycle
//   fifo_count   out  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH
//   overflow     out  1      sticky: a sample was dropped on full FIFO
//   spike_count  out  8      total spikes since reset/clear, wraps 255->0
// BEHAVIOUR
// - Reset (rst or clear): isi_cnt=0, armed=0, FIFO empty, isi_valid=0,
//   isi_data=0, fifo_count=0, overflow=0, spike_count=0. clear outranks all
//   same-cycle events; rst outranks clear.
// - ISI counter
//   - +1 on each step_en; saturates at 2^ISI_W-1 (no wrap).
//   - On spike, value sampled = isi_cnt before this cycle's increment. Next
//     isi_cnt = step_en ? 1 : 0.
// - Arming: first spike after reset/clear pushes nothing. It sets armed=1 and
//   restarts the counter. Every later spike pushes one sample.
// - spike_count increments on every spike, armed or not, wraps modulo 256.
// - FIFO
//   - push = spike & armed; pop = isi_valid & isi_ready.
//   - Write latency 1: spike at cycle N into empty FIFO gives isi_valid=1 and
//     isi_data=sample at N+1.
//   - isi_data is the head entry. It is held stable while isi_valid & !isi_ready.
//   - Full, push, no pop: sample dropped, overflow<=1, contents unchanged.
//   - Full, push and pop together: both happen, count stays FIFO_DEPTH, no
//     overflow.
//   - Empty: pop cannot occur (valid=0). Push and pop never collide on the same
//     entry.
//   - Pointers wrap modulo FIFO_DEPTH. fifo_count = wr-rd, using the extra MSB.
// - overflow clears only on rst/clear.
// - spike and step_en high in the same cycle: the sample excludes that step,
//   and the new interval starts at 1.
// - All outputs are registered. There are no combinational paths from inputs
//   to outputs.
// TESTING
// 1. rst 2 cycles -> all outputs 0; spike with no prior spike -> no push,
//    spike_count=1.
// 2. spike, 5 step_en, spike -> next cycle isi_valid=1, isi_data=5,
//    fifo_count=1; isi_ready=1 one cycle -> isi_valid=0.
// 3. spike and step_en same cycle after 3 steps -> sample 3, next ISI begins
//    at 1; 2 more steps then spike -> sample 3.
// 4. isi_ready=0; arm, then 5 spikes with ISIs 1,2,3,4,5 -> fifo_count=4,
//    overflow=1; drain order 1,2,3,4.
// 5. FIFO full, spike with isi_ready=1 -> head popped, new sample appended,
//    fifo_count=4, overflow stays 0.
// 6. 300 steps without spike -> sample 255 (saturated); clear with 2 entries
//    queued -> FIFO empty, disarmed, spike_count=0.

Source files
------------

// File: rtl/adex_isi_encoder_if.sv
// rtl/adex_isi_encoder_if.sv - ISI sample valid/ready byte stream
interface adex_isi_encoder_if #(
    parameter int ISI_W = 8
);
    logic [ISI_W-1:0] isi_data;
    logic             isi_valid;
    logic             isi_ready;

    modport master (output isi_data, output isi_valid, input isi_ready);
    modport slave  (input isi_data, input isi_valid, output isi_ready);
endinterface

// File: rtl/adex_isi_encoder.sv
// rtl/adex_isi_encoder.sv - inter-spike interval encoder with sample FIFO and spike tally
module adex_isi_encoder #(
    parameter int ISI_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_en,
    input  logic                 spike,
    input  logic                 clear,
    adex_isi_encoder_if.master   isi,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 overflow,
    output logic [7:0]           spike_count
);
    localparam int               AW      = CNT_W - 1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic [ISI_W-1:0] mem [FIFO_DEPTH];
    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] isi_cnt_nxt;
    logic [ISI_W-1:0] head_nxt;
    logic             armed;
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] wr_nxt;
    logic [CNT_W-1:0] rd_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;

    always_comb begin
        push  = spike & armed;
        pop   = isi.isi_valid & isi.isi_ready;
        full  = (fifo_count == CNT_W'(FIFO_DEPTH));
        // A simultaneous pop frees the head slot, so a full FIFO can still accept.
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;

        wr_nxt  = wr_ptr + CNT_W'(wr_en);
        rd_nxt  = rd_ptr + CNT_W'(pop);
        cnt_nxt = wr_nxt - rd_nxt;

        // Output head is registered, so bypass the sample that lands in the new head slot.
        head_nxt = '0;
        if (cnt_nxt != '0) begin
            if (wr_en && (wr_ptr == rd_nxt))
                head_nxt = isi_cnt;
            else
                head_nxt = mem[rd_nxt[AW-1:0]];
        end

        isi_cnt_nxt = isi_cnt;
        if (spike)
            isi_cnt_nxt = step_en ? ISI_W'(1) : '0;
        else if (step_en && (isi_cnt != ISI_MAX))
            isi_cnt_nxt = isi_cnt + ISI_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear && wr_en)
            mem[wr_ptr[AW-1:0]] <= isi_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            isi_cnt       <= '0;
            armed         <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            isi.isi_valid <= 1'b0;
            isi.isi_data  <= '0;
            overflow      <= 1'b0;
            spike_count   <= '0;
        end else begin
            isi_cnt       <= isi_cnt_nxt;
            if (spike)
                armed     <= 1'b1;
            wr_ptr        <= wr_nxt;
            rd_ptr        <= rd_nxt;
            fifo_count    <= cnt_nxt;
            isi.isi_valid <= (cnt_nxt != '0);
            isi.isi_data  <= head_nxt;
            if (drop)
                overflow  <= 1'b1;
            spike_count   <= spike_count + 8'(spike);
        end
    end
endmodule

// File: tb/tb_adex_isi_encoder.sv
// tb/tb_adex_isi_encoder.sv - directed bench with queue-based ISI reference model
module tb_adex_isi_encoder;
    localparam int ISI_W = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             step_en;
    logic             spike;
    logic             clear;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic [7:0]       spike_count;

    adex_isi_encoder_if #(.ISI_W(ISI_W)) isi_if ();

    adex_isi_encoder #(.ISI_W(ISI_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .step_en     (step_en),
        .spike       (spike),
        .clear       (clear),
        .isi         (isi_if.master),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    int q[$];
    int m_cnt   = 0;
    bit m_armed = 0;
    bit m_ovf   = 0;
    int m_spk   = 0;
    bit live    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO is a plain queue, ISI is a saturating integer.
    always @(posedge clk) begin : model
        bit pop;
        if (rst || clear) begin
            q.delete();
            m_cnt   = 0;
            m_armed = 0;
            m_ovf   = 0;
            m_spk   = 0;
        end else begin
            pop = (q.size() > 0) && (isi_if.isi_ready === 1'b1);
            if (pop)
                void'(q.pop_front());
            if (spike) begin
                if (m_armed) begin
                    if (q.size() < DEPTH) q.push_back(m_cnt);
                    else m_ovf = 1;
                end
                m_armed = 1;
                m_spk   = (m_spk + 1) % 256;
                m_cnt   = step_en ? 1 : 0;
            end else if (step_en && m_cnt < 255) begin
                m_cnt++;
            end
        end
        live = 1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("isi_valid", int'(isi_if.isi_valid), int'(q.size() > 0));
            chk("fifo_count", int'(fifo_count), q.size());
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("spike_count", int'(spike_count), m_spk);
            if (q.size() > 0)
                chk("isi_data", int'(isi_if.isi_data), q[0]);
        end
    end

    task automatic cyc(input bit sp, input bit st, input bit rd);
        spike            = sp;
        step_en          = st;
        isi_if.isi_ready = rd;
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(0, 0, 0);
        clear = 1'b0;
    endtask

    task automatic steps(input int n, input bit rd);
        for (int i = 0; i < n; i++) cyc(0, 1, rd);
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        spike = 1'b0;
        step_en = 1'b0;
        isi_if.isi_ready = 1'b0;

        // 1: reset, then first spike only arms
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
        chk("rst_valid", int'(isi_if.isi_valid), 0);
        chk("rst_data", int'(isi_if.isi_data), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_spk", int'(spike_count), 0);
        cyc(1, 0, 0);
        chk("arm_count", int'(fifo_count), 0);
        chk("arm_spk", int'(spike_count), 1);

        // 2: ISI of 5 steps, then a single pop
        steps(5, 0);
        cyc(1, 0, 0);
        chk("t2_valid", int'(isi_if.isi_valid), 1);
        chk("t2_data", int'(isi_if.isi_data), 5);
        chk("t2_count", int'(fifo_count), 1);
        cyc(0, 0, 1);
        chk("t2_pop_valid", int'(isi_if.isi_valid), 0);

        // 3: spike coincident with step excludes that step, new ISI starts at 1
        steps(3, 0);
        cyc(1, 1, 0);
        chk("t3_first", int'(isi_if.isi_data), 3);
        steps(2, 0);
        cyc(1, 0, 0);
        chk("t3_count", int'(fifo_count), 2);
        cyc(0, 0, 1);
        chk("t3_second", int'(isi_if.isi_data), 3);
        cyc(0, 0, 1);

        // 4: overfill with no consumer
        do_clear();
        cyc(1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            steps(k, 0);
            cyc(1, 0, 0);
        end
        chk("t4_count", int'(fifo_count), 4);
        chk("t4_ovf", int'(overflow), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("t4_drain", int'(isi_if.isi_data), k);
            cyc(0, 0, 1);
        end
        chk("t4_empty", int'(isi_if.isi_valid), 0);
        chk("t4_ovf_sticky", int'(overflow), 1);

        // 5: full FIFO with simultaneous push and pop
        do_clear();
        cyc(1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            steps(k, 0);
            cyc(1, 0, 0);
        end
        chk("t5_full", int'(fifo_count), 4);
        steps(7, 0);
        cyc(1, 0, 1);
        chk("t5_count", int'(fifo_count), 4);
        chk("t5_ovf", int'(overflow), 0);
        chk("t5_head", int'(isi_if.isi_data), 2);
        cyc(0, 0, 1);
        chk("t5_d3", int'(isi_if.isi_data), 3);
        cyc(0, 0, 1);
        chk("t5_d4", int'(isi_if.isi_data), 4);
        cyc(0, 0, 1);
        chk("t5_d7", int'(isi_if.isi_data), 7);
        cyc(0, 0, 1);

        // 6: saturation, then clear with entries queued
        do_clear();
        cyc(1, 0, 0);
        steps(300, 0);
        cyc(1, 0, 0);
        chk("t6_sat", int'(isi_if.isi_data), 255);
        steps(1, 0);
        cyc(1, 0, 0);
        chk("t6_count", int'(fifo_count), 2);
        do_clear();
        chk("t6_clr_count", int'(fifo_count), 0);
        chk("t6_clr_valid", int'(isi_if.isi_valid), 0);
        chk("t6_clr_spk", int'(spike_count), 0);
        steps(2, 0);
        cyc(1, 0, 0);
        chk("t6_disarmed", int'(fifo_count), 0);
        chk("t6_spk", int'(spike_count), 1);
        steps(2, 0);
        cyc(1, 0, 0);
        chk("t6_rearmed", int'(isi_if.isi_data), 2);
        cyc(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
